// File: rtl/riscv_pkg.sv
// Shared RV64 fetch-side definitions: datapath widths, fetch FSM states, NOP encoding.
package riscv_pkg;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned INST_W = 32;

  localparam logic [INST_W-1:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } fetch_state_e;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetch_unit.sv
// Single-outstanding instruction fetch unit: PC register, fetch FSM and a
// decoder-facing output register, with redirect and misaligned-target flagging.
module inst_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 64'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic              imem_req,
  output logic [XLEN-1:0]   imem_addr,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_out,
  output logic [XLEN-1:0]   inst_pc,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              misalign_err
);

  fetch_state_e      state_q, state_d;
  fetch_state_e      resume;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   inst_pc_q, inst_pc_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic              drop_q, drop_d;
  logic              valid_q, valid_d;
  logic              mis_q, mis_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      drop_q    <= 1'b0;
      valid_q   <= 1'b0;
      inst_q    <= '0;
      inst_pc_q <= '0;
      mis_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      drop_q    <= drop_d;
      valid_q   <= valid_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      mis_q     <= mis_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    drop_d    = drop_q;
    valid_d   = valid_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    mis_d     = 1'b0;
    resume    = en ? REQ : IDLE;

    if (redirect_valid) begin
      pc_d    = align_word(redirect_pc);
      valid_d = 1'b0;
      mis_d   = |redirect_pc[1:0];
      drop_d  = 1'b0;
      state_d = resume;
      // A request still in flight must be drained before the new PC is fetched;
      // a response arriving in the redirect cycle itself is simply discarded.
      if ((state_q == WAIT && !imem_rvalid) || (state_q == REQ && imem_ready)) begin
        drop_d  = 1'b1;
        state_d = WAIT;
      end
    end else begin
      case (state_q)
        IDLE: if (en) state_d = REQ;
        REQ:  if (imem_ready) state_d = WAIT;
        WAIT: begin
          if (imem_rvalid) begin
            if (drop_q) begin
              drop_d  = 1'b0;
              state_d = resume;
            end else begin
              inst_d    = imem_rdata;
              inst_pc_d = pc_q;
              valid_d   = 1'b1;
              pc_d      = pc_q + XLEN'(4);
              state_d   = HOLD;
            end
          end
        end
        HOLD: begin
          if (inst_ready) begin
            valid_d = 1'b0;
            state_d = resume;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign imem_req     = (state_q == REQ);
  assign imem_addr    = pc_q;
  assign inst_valid   = valid_q;
  assign inst_out     = inst_q;
  assign inst_pc      = inst_pc_q;
  assign misalign_err = mis_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit: randomised memory/decoder/redirect traffic
// checked against a PC-stream reference model, plus directed corner scenarios.
module tb_inst_fetch_unit;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_out;
  logic [63:0] inst_pc;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        misalign_err;

  logic        en2 = 1'b0;
  logic        imem_req2;
  logic [63:0] imem_addr2;
  logic        imem_ready2 = 1'b1;
  logic        imem_rvalid2 = 1'b0;
  logic [31:0] imem_rdata2 = '0;
  logic        inst_valid2;
  logic        inst_ready2 = 1'b1;
  logic [31:0] inst_out2;
  logic [63:0] inst_pc2;
  logic        redirect_valid2 = 1'b0;
  logic [63:0] redirect_pc2 = '0;
  logic        misalign_err2;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] exp_pc = 64'h0;
  logic [63:0] acc_q[$];
  logic [31:0] mem_ovr[logic [63:0]];
  int          checks = 0;
  int          errors = 0;
  int          n_consumed = 0;
  int          ready_pct = 100;
  int          dly_lo = 0;
  int          dly_hi = 0;
  bit          wrap_done = 0;

  always #5 clk = ~clk;

  inst_fetch_unit #(.RESET_PC(64'h0)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_out(inst_out), .inst_pc(inst_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .misalign_err(misalign_err)
  );

  inst_fetch_unit #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) u_dut_wrap (
    .clk(clk), .rst_n(rst_n), .en(en2),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ready(imem_ready2),
    .imem_rvalid(imem_rvalid2), .imem_rdata(imem_rdata2),
    .inst_valid(inst_valid2), .inst_ready(inst_ready2), .inst_out(inst_out2), .inst_pc(inst_pc2),
    .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2), .misalign_err(misalign_err2)
  );

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (mem_ovr.exists(a)) return mem_ovr[a];
    return a[31:0] ^ {a[63:34], 2'b01} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  task automatic restart_model(input logic [63:0] pc);
    exp_pc = pc;
    exp_q.delete();
    exp_q.push_back('{pc: pc, data: mem_word(pc)});
  endtask

  // One decoder/redirect cycle; the expected next instruction follows the PC rules.
  task automatic step(input logic e, input logic rdy, input logic rv, input logic [63:0] rpc);
    @(negedge clk);
    en = e;
    inst_ready = rdy;
    redirect_valid = rv;
    redirect_pc = rpc;
    #2;
    if (rst_n) begin
      if (rv) restart_model(align_word(rpc));
      else if (inst_valid && rdy) restart_model(exp_pc + 64'd4);
    end
  endtask

  task automatic check_reset_outputs();
    chkb("rst_imem_req", imem_req, 1'b0);
    chk("rst_imem_addr", imem_addr, 64'h0);
    chkb("rst_inst_valid", inst_valid, 1'b0);
    chk("rst_inst_out", 64'(inst_out), 64'h0);
    chk("rst_inst_pc", inst_pc, 64'h0);
    chkb("rst_misalign", misalign_err, 1'b0);
  endtask

  initial begin : mem_model
    bit          pend;
    int          cnt;
    logic [63:0] paddr;
    pend = 0;
    cnt = 0;
    paddr = '0;
    forever begin
      @(negedge clk);
      imem_rvalid = 1'b0;
      if (pend) begin
        if (cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata = mem_word(paddr);
          pend = 0;
        end else begin
          cnt--;
        end
      end
      imem_ready = ($urandom_range(99) < ready_pct);
      if (rst_n && imem_req && imem_ready) begin
        chkb("one_outstanding", pend || imem_rvalid, 1'b0);
        pend = 1;
        paddr = imem_addr;
        cnt = int'($urandom_range(dly_hi, dly_lo));
        acc_q.push_back(imem_addr);
      end
    end
  end

  initial begin : monitor
    logic        pv, prdy, prv, preq, pready, predir, mis_exp;
    logic [31:0] pout;
    logic [63:0] ppc, paddr;
    exp_t        e;
    pv = 0; prdy = 0; prv = 0; preq = 0; pready = 0; predir = 0; mis_exp = 0;
    pout = '0; ppc = '0; paddr = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        pv = 0; prv = 0; preq = 0; predir = 0; mis_exp = 0;
        continue;
      end
      chkb("misalign_err", misalign_err, mis_exp);
      if (predir) chkb("redirect_clears_valid", inst_valid, 1'b0);
      if (pv && !prdy && !predir) begin
        chkb("hold_valid", inst_valid, 1'b1);
        chk("hold_inst_out", 64'(inst_out), 64'(pout));
        chk("hold_inst_pc", inst_pc, ppc);
      end
      if (preq && !pready && !predir) begin
        chkb("req_held", imem_req, 1'b1);
        chk("req_addr_held", imem_addr, paddr);
      end
      if (inst_valid && !pv) chkb("valid_after_rvalid", prv, 1'b1);
      if (inst_valid) chkb("no_req_while_valid", imem_req, 1'b0);
      if (inst_valid && inst_ready) begin
        if (exp_q.size() == 0) begin
          timeout("unexpected_inst");
        end else begin
          e = exp_q.pop_front();
          chk("inst_pc", inst_pc, e.pc);
          chk("inst_out", 64'(inst_out), 64'(e.data));
        end
        n_consumed++;
      end
      mis_exp = redirect_valid && (redirect_pc[1:0] != 2'b00);
      pv = inst_valid; prdy = inst_ready; prv = imem_rvalid;
      preq = imem_req; pready = imem_ready; predir = redirect_valid;
      pout = inst_out; ppc = inst_pc; paddr = imem_addr;
    end
  end

  initial begin : wrap_test
    logic [63:0] acc2[$];
    logic [63:0] pc2[$];
    bit          p;
    p = 0;
    wait (rst_n);
    @(negedge clk);
    en2 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      imem_rvalid2 = p;
      imem_rdata2 = NOP;
      p = imem_req2;
      if (imem_req2) acc2.push_back(imem_addr2);
      if (inst_valid2) pc2.push_back(inst_pc2);
    end
    if (acc2.size() < 2 || pc2.size() < 2) begin
      timeout("wrap_fetches");
    end else begin
      chk("wrap_addr0", acc2[0], 64'hFFFF_FFFF_FFFF_FFFC);
      chk("wrap_addr1", acc2[1], 64'h0);
      chk("wrap_pc0", pc2[0], 64'hFFFF_FFFF_FFFF_FFFC);
      chk("wrap_pc1", pc2[1], 64'h0);
    end
    wrap_done = 1;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int          n0;
    int          k;
    logic [63:0] rpc;
    mem_ovr[64'h0]   = NOP;
    mem_ovr[64'h4]   = NOP;
    mem_ovr[64'h100] = 32'h00A5_0533;
    restart_model(64'h0);
    #3;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Zero-wait fetch of 0x0 and 0x4, then 0x8 requested.
    k = 0;
    while (n_consumed < 2 && k < 20) begin step(1, 1, 0, '0); k++; end
    if (n_consumed < 2) timeout("first_two_fetches");
    dly_lo = 4; dly_hi = 4;
    k = 0;
    while (acc_q.size() < 3 && k < 10) begin step(1, 1, 0, '0); k++; end
    if (acc_q.size() < 3) begin
      timeout("addr_seq");
    end else begin
      chk("addr_seq0", acc_q[0], 64'h0);
      chk("addr_seq1", acc_q[1], 64'h4);
      chk("addr_seq2", acc_q[2], 64'h8);
    end

    // Redirect while waiting on 0x8.
    step(1, 1, 1, 64'h100);
    dly_lo = 1; dly_hi = 1;
    k = 0;
    while (acc_q.size() < 4 && k < 20) begin step(1, 1, 0, '0); k++; end
    if (acc_q.size() < 4) timeout("redirect_addr");
    else chk("redirect_addr", acc_q[3], 64'h100);

    // Decoder stall for 5 cycles on the 0x100 instruction.
    k = 0;
    do begin step(1, 0, 0, '0); k++; end while (!inst_valid && k < 20);
    if (!inst_valid) timeout("stall_valid");
    chk("stall_inst_out", 64'(inst_out), 64'h00A5_0533);
    chk("stall_inst_pc", inst_pc, 64'h100);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, '0);
      chkb("stall_no_req", imem_req, 1'b0);
    end
    step(1, 1, 0, '0);

    // Misaligned redirect coincident with an accepted request.
    step(1, 1, 1, 64'h102);
    n0 = acc_q.size();
    step(1, 1, 0, '0);
    chkb("misalign_pulse_hi", misalign_err, 1'b1);
    step(1, 1, 0, '0);
    chkb("misalign_pulse_lo", misalign_err, 1'b0);
    k = 0;
    while (acc_q.size() <= n0 && k < 20) begin step(1, 1, 0, '0); k++; end
    if (acc_q.size() <= n0) timeout("misalign_addr");
    else chk("misalign_addr", acc_q[n0], 64'h100);

    // Reset in the middle of a request; the late response must be ignored.
    dly_lo = 3; dly_hi = 3;
    n0 = acc_q.size();
    k = 0;
    while (acc_q.size() <= n0 && k < 20) begin step(1, 1, 0, '0); k++; end
    if (acc_q.size() <= n0) timeout("pre_reset_req");
    step(1, 1, 0, '0);
    @(negedge clk);
    rst_n = 1'b0;
    en = 1'b0;
    #1;
    check_reset_outputs();
    restart_model(64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 0, '0);
      chkb("late_rvalid_ignored", inst_valid, 1'b0);
      chkb("idle_no_req", imem_req, 1'b0);
    end
    n0 = acc_q.size();
    k = 0;
    while (acc_q.size() <= n0 && k < 10) begin step(1, 1, 0, '0); k++; end
    if (acc_q.size() <= n0) timeout("restart_addr");
    else chk("restart_addr", acc_q[n0], 64'h0);

    // Randomised traffic.
    ready_pct = 70; dly_lo = 0; dly_hi = 3;
    n0 = n_consumed;
    for (int i = 0; i < 2000; i++) begin
      case ($urandom_range(2))
        0:       rpc = {48'h0, 16'($urandom)};
        1:       rpc = 64'hFFFF_FFFF_FFFF_FFE0 | 64'($urandom_range(31));
        default: rpc = {$urandom, $urandom};
      endcase
      step($urandom_range(9) != 0, 1'($urandom_range(1)), $urandom_range(19) == 0, rpc);
    end
    ready_pct = 100;
    for (int i = 0; i < 20; i++) step(1, 1, 0, '0);
    chkb("random_progress", (n_consumed - n0) > 100, 1'b1);

    if (!wrap_done) timeout("wrap_test_done");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch_unit.md
INST_FETCH_UNIT -- requirements
Module: inst_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 64'h0, SHALL set the first fetch address after reset.
REQ-002 Port clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 Port rst_n  input  1  SHALL be the reset: asynchronous assert, active-low.
REQ-004 Port en  input  1  SHALL enable fetching (level).
REQ-005 Port imem_req  output  1  SHALL be the instruction-memory request valid.
REQ-006 Port imem_addr  output  64  SHALL be the request byte address.
REQ-007 Port imem_ready  input  1  SHALL be the memory accept (request taken when imem_req && imem_ready).
REQ-008 Port imem_rvalid  input  1  SHALL be the response valid, one cycle, at least one cycle after acceptance.
REQ-009 Port imem_rdata  input  32  SHALL be the instruction word, valid with imem_rvalid.
REQ-010 Port inst_valid  output  1  SHALL flag a valid instruction to the decoder.
REQ-011 Port inst_ready  input  1  SHALL be the decoder accept (consume on inst_valid && inst_ready).
REQ-012 Port inst_out  output  32  SHALL carry the fetched instruction.
REQ-013 Port inst_pc  output  64  SHALL carry the address of inst_out.
REQ-014 Port redirect_valid  input  1  SHALL request a PC change (branch/jump), single-cycle.
REQ-015 Port redirect_pc  input  64  SHALL be the redirect target, valid with redirect_valid.
REQ-016 Port misalign_err  output  1  SHALL pulse one cycle when a redirect target has [1:0] != 2'b00.

Function
REQ-017 States SHALL be IDLE, REQ, WAIT, HOLD; at most one memory request outstanding.
REQ-018 IDLE: imem_req=0, inst_valid=0; en=1 -> REQ next cycle.
REQ-019 REQ: imem_req=1, imem_addr=pc, both held stable until imem_ready; on acceptance -> WAIT.
REQ-020 WAIT: imem_rvalid with drop=0 -> inst_out=imem_rdata, inst_pc=pc, inst_valid=1, pc=pc+4, -> HOLD.
REQ-021 WAIT: imem_rvalid with drop=1 -> response discarded, drop cleared, -> REQ (or IDLE if en=0).
REQ-022 HOLD: inst_out/inst_pc stable while inst_valid && !inst_ready; on consume -> inst_valid=0, -> REQ if en=1 else IDLE.
REQ-023 pc+4 SHALL wrap modulo 2^64 (64'hFFFF_FFFF_FFFF_FFFC -> 64'h0).
REQ-024 Latency: inst_valid SHALL rise the cycle after the imem_rvalid cycle; minimum 3 cycles per instruction.
REQ-025 Redirect in any state SHALL load pc=redirect_pc with [1:0] forced to 2'b00 and clear inst_valid next cycle.
REQ-026 Redirect in WAIT, or in REQ coincident with imem_ready, SHALL set drop=1 and enter/stay in WAIT; otherwise -> REQ (IDLE if en=0).
REQ-027 Redirect in HOLD coincident with inst_ready: instruction counts consumed; redirect still applies.
REQ-028 Redirect coincident with imem_rvalid in WAIT SHALL discard that response and -> REQ.
REQ-029 en deasserted in REQ/WAIT SHALL let the current request complete and deliver; return to IDLE after consume.
REQ-030 imem_rvalid outside WAIT SHALL be ignored.

Reset
REQ-031 rst_n=0 SHALL immediately force: state=IDLE, pc=RESET_PC, drop=0, imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst_out=32'h0, inst_pc=64'h0, misalign_err=0.
REQ-032 Reset mid-request SHALL abandon it; the instruction memory is reset with the same rst_n.

Structure
REQ-033 Shared package riscv_pkg SHALL hold XLEN=64, INST_W=32, the fetch state enum and the NOP encoding 32'h0000_0013.
REQ-034 Single module, no sub-module; PC register, FSM and output register inline.

Verification
REQ-035 Reset, en=1, zero-wait memory returning 32'h0000_0013 at 0x0,0x4 -> inst_pc 0x0 then 0x4, imem_addr sequence 0x0,0x4,0x8.
REQ-036 inst_ready=0 for 5 cycles with inst_out=32'h00A5_0533 -> inst_out/inst_pc stable, no new imem_req until consume.
REQ-037 Redirect to 0x100 while in WAIT for 0x8 -> 0x8 response dropped, next imem_addr=0x100, next inst_pc=0x100.
REQ-038 Redirect to 0x102 -> misalign_err one-cycle pulse, next imem_addr=0x100.
REQ-039 RESET_PC=64'hFFFF_FFFF_FFFF_FFFC, two fetches -> imem_addr FFFF_FFFF_FFFF_FFFC then 0x0.
REQ-040 rst_n low during WAIT -> all outputs at reset values same cycle, late imem_rvalid ignored, restart at RESET_PC.
